// File: rtl/edge_map_reader_pkg.sv
// Shared constants and FSM encoding for the edge-map readout path.
package edge_map_reader_pkg;

  localparam int EDGE_MAP_BASE   = 2240;
  localparam int EDGE_MAP_END    = 74561;
  localparam int EDGE_MAP_PIXELS = EDGE_MAP_END - EDGE_MAP_BASE;
  localparam int SRAM_ADDR_W     = 18;
  localparam int CNT_W           = 17;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_CAPTURE,
    S_EMIT,
    S_DONE
  } state_t;

endpackage

// File: rtl/edge_map_reader.sv
// Reads the edge map (2 cycles/pixel), packs 8 flags per byte LSB-first, streams them out.
// Backpressure: byte held with no SRAM reads while out_ready is low; pause freezes everything.
module edge_map_reader
  import edge_map_reader_pkg::*;
#(
  parameter int START_ADDR  = EDGE_MAP_BASE,
  parameter int PIXEL_COUNT = EDGE_MAP_PIXELS,
  parameter int ADDR_W      = SRAM_ADDR_W
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              pause,
  input  logic              enable_edge_readout,
  input  logic [31:0]       data_read,
  output logic [ADDR_W-1:0] address,
  output logic [7:0]        out_byte,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CNT_W-1:0]  edge_count,
  output logic              edge_readout_done
);

  state_t            r_state,     w_state_nxt;
  logic [ADDR_W-1:0] r_addr_ptr,  w_addr_ptr_nxt;
  logic [CNT_W-1:0]  r_pix_left,  w_pix_left_nxt;
  logic [2:0]        r_bit_idx,   w_bit_idx_nxt;
  logic [7:0]        r_shift,     w_shift_nxt;
  logic [CNT_W-1:0]  r_count,     w_count_nxt;
  logic [ADDR_W-1:0] r_address,   w_address_nxt;
  logic [7:0]        r_out_byte,  w_out_byte_nxt;
  logic              r_out_valid, w_out_valid_nxt;
  logic              r_done,      w_done_nxt;
  logic              r_replay,    w_replay_nxt;
  logic              w_flag;

  assign w_flag = |data_read;

  always_comb begin
    w_state_nxt     = r_state;
    w_addr_ptr_nxt  = r_addr_ptr;
    w_pix_left_nxt  = r_pix_left;
    w_bit_idx_nxt   = r_bit_idx;
    w_shift_nxt     = r_shift;
    w_count_nxt     = r_count;
    w_address_nxt   = r_address;
    w_out_byte_nxt  = r_out_byte;
    w_out_valid_nxt = r_out_valid;
    w_done_nxt      = r_done;
    w_replay_nxt    = 1'b0;

    if (!enable_edge_readout) begin
      w_state_nxt     = S_IDLE;
      w_address_nxt   = '0;
      w_out_valid_nxt = 1'b0;
      w_out_byte_nxt  = '0;
      w_done_nxt      = 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (!r_done) begin
            w_addr_ptr_nxt = ADDR_W'(START_ADDR);
            w_pix_left_nxt = CNT_W'(PIXEL_COUNT);
            w_bit_idx_nxt  = '0;
            w_shift_nxt    = '0;
            w_count_nxt    = '0;
            w_address_nxt  = ADDR_W'(START_ADDR);
            w_state_nxt    = S_ISSUE;
          end
        end
        S_ISSUE: w_state_nxt = S_CAPTURE;
        S_CAPTURE: begin
          // The SRAM port may have served another master while paused: re-issue the read.
          if (r_replay) begin
            w_state_nxt = S_ISSUE;
          end else begin
            w_shift_nxt    = r_shift | (8'(w_flag) << r_bit_idx);
            w_count_nxt    = r_count + CNT_W'(w_flag);
            w_addr_ptr_nxt = r_addr_ptr + 1'b1;
            w_pix_left_nxt = r_pix_left - 1'b1;
            w_bit_idx_nxt  = r_bit_idx + 1'b1;
            if (r_bit_idx == 3'd7 || r_pix_left == CNT_W'(1)) begin
              w_out_byte_nxt  = w_shift_nxt;
              w_out_valid_nxt = 1'b1;
              w_state_nxt     = S_EMIT;
            end else begin
              w_address_nxt = r_addr_ptr + 1'b1;
              w_state_nxt   = S_ISSUE;
            end
          end
        end
        S_EMIT: begin
          if (r_out_valid && out_ready) begin
            w_out_valid_nxt = 1'b0;
            w_shift_nxt     = '0;
            w_bit_idx_nxt   = '0;
            if (r_pix_left != '0) begin
              w_address_nxt = r_addr_ptr;
              w_state_nxt   = S_ISSUE;
            end else begin
              w_address_nxt = '0;
              w_done_nxt    = 1'b1;
              w_state_nxt   = S_DONE;
            end
          end
        end
        S_DONE: begin
          w_address_nxt = '0;
          w_done_nxt    = 1'b1;
        end
        default: w_state_nxt = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state     <= S_IDLE;
      r_addr_ptr  <= '0;
      r_pix_left  <= '0;
      r_bit_idx   <= '0;
      r_shift     <= '0;
      r_count     <= '0;
      r_address   <= '0;
      r_out_byte  <= '0;
      r_out_valid <= 1'b0;
      r_done      <= 1'b0;
      r_replay    <= 1'b0;
    end else if (pause) begin
      r_replay <= r_replay | (r_state == S_CAPTURE);
    end else begin
      r_state     <= w_state_nxt;
      r_addr_ptr  <= w_addr_ptr_nxt;
      r_pix_left  <= w_pix_left_nxt;
      r_bit_idx   <= w_bit_idx_nxt;
      r_shift     <= w_shift_nxt;
      r_count     <= w_count_nxt;
      r_address   <= w_address_nxt;
      r_out_byte  <= w_out_byte_nxt;
      r_out_valid <= w_out_valid_nxt;
      r_done      <= w_done_nxt;
      r_replay    <= w_replay_nxt;
    end
  end

  assign address           = r_address;
  assign out_byte          = r_out_byte;
  assign out_valid         = r_out_valid;
  assign edge_count        = r_count;
  assign edge_readout_done = r_done;

endmodule

// File: tb/tb_edge_map_reader.sv
// Directed bench for edge_map_reader on a 17-pixel map (two full bytes plus a 1-flag tail byte).
module tb_edge_map_reader;

  localparam int SA = 2240;
  localparam int PC = 17;
  localparam int AW = 18;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic          pause = 1'b0;
  logic          enable = 1'b0;
  logic [31:0]   data_read = '0;
  logic [AW-1:0] address;
  logic [7:0]    out_byte;
  logic          out_valid;
  logic          out_ready = 1'b1;
  logic [16:0]   edge_count;
  logic          done;

  logic [31:0] mem [0:PC-1];
  logic [7:0]  byte_q [$];
  bit          timed_out;
  int          n_checks = 0;
  int          n_fail = 0;

  edge_map_reader #(.START_ADDR(SA), .PIXEL_COUNT(PC), .ADDR_W(AW)) dut (
    .clk                 (clk),
    .reset_n             (reset_n),
    .pause               (pause),
    .enable_edge_readout (enable),
    .data_read           (data_read),
    .address             (address),
    .out_byte            (out_byte),
    .out_valid           (out_valid),
    .out_ready           (out_ready),
    .edge_count          (edge_count),
    .edge_readout_done   (done)
  );

  always #5 clk = ~clk;

  // 1-cycle SRAM; while paused the shared port returns another master's data.
  always @(posedge clk) begin
    if (pause) data_read <= 32'hFFFF_FFFF;
    else if (int'(address) >= SA && int'(address) < SA + PC) data_read <= mem[int'(address) - SA];
    else data_read <= 32'hA5A5_A5A5;
  end

  task automatic collect(input int max_cycles);
    byte_q.delete();
    timed_out = 1'b1;
    for (int c = 0; c < max_cycles; c++) begin
      @(negedge clk);
      if (done) begin
        timed_out = 1'b0;
        break;
      end
      if (out_valid && out_ready) byte_q.push_back(out_byte);
    end
  endtask

  task automatic wait_valid(input int max_cycles, output bit ok);
    ok = 1'b0;
    for (int c = 0; c < max_cycles; c++) begin
      @(negedge clk);
      if (out_valid) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic restart_idle();
    enable = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    for (int i = 0; i < PC; i++) mem[i] = '0;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    n_checks++; if (address !== '0) begin n_fail++; $display("FAIL reset_address got %0d exp 0", address); end
    n_checks++; if (out_byte !== 8'h00) begin n_fail++; $display("FAIL reset_out_byte got %h exp 00", out_byte); end
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid got %b exp 0", out_valid); end
    n_checks++; if (edge_count !== '0) begin n_fail++; $display("FAIL reset_edge_count got %0d exp 0", edge_count); end
    n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL reset_done got %b exp 0", done); end
  endtask

  task automatic test_all_zero();
    logic [7:0] exp_b [3] = '{8'h00, 8'h00, 8'h00};
    restart_idle();
    enable = 1'b1;
    collect(300);
    n_checks++; if (timed_out) begin n_fail++; $display("FAIL zero_timeout got timeout exp done"); end
    n_checks++; if (byte_q.size() != 3) begin n_fail++; $display("FAIL zero_nbytes got %0d exp 3", byte_q.size()); end
    for (int i = 0; i < 3; i++) begin
      n_checks++;
      if (i >= byte_q.size() || byte_q[i] !== exp_b[i]) begin n_fail++; $display("FAIL zero_byte%0d exp %h", i, exp_b[i]); end
    end
    n_checks++; if (edge_count !== 17'd0) begin n_fail++; $display("FAIL zero_count got %0d exp 0", edge_count); end
    n_checks++; if (done !== 1'b1 || address !== '0) begin n_fail++; $display("FAIL zero_final got done=%b addr=%0d exp 1/0", done, address); end
  endtask

  task automatic test_first_byte();
    logic [7:0] exp_b [3] = '{8'h81, 8'h00, 8'h00};
    restart_idle();
    mem[0] = 32'h0000_0001;
    mem[7] = 32'hFFFF_FFFF;
    enable = 1'b1;
    collect(300);
    n_checks++; if (timed_out || byte_q.size() != 3) begin n_fail++; $display("FAIL first_nbytes got %0d exp 3", byte_q.size()); end
    for (int i = 0; i < 3; i++) begin
      n_checks++;
      if (i >= byte_q.size() || byte_q[i] !== exp_b[i]) begin n_fail++; $display("FAIL first_byte%0d exp %h", i, exp_b[i]); end
    end
    n_checks++; if (edge_count !== 17'd2) begin n_fail++; $display("FAIL first_count got %0d exp 2", edge_count); end
  endtask

  task automatic test_all_ones();
    logic [7:0] exp_b [3] = '{8'hFF, 8'hFF, 8'h01};
    restart_idle();
    for (int i = 0; i < PC; i++) mem[i] = 32'h1 << (i * 3 % 32);
    enable = 1'b1;
    collect(300);
    n_checks++; if (timed_out || byte_q.size() != 3) begin n_fail++; $display("FAIL ones_nbytes got %0d exp 3", byte_q.size()); end
    for (int i = 0; i < 3; i++) begin
      n_checks++;
      if (i >= byte_q.size() || byte_q[i] !== exp_b[i]) begin n_fail++; $display("FAIL ones_byte%0d exp %h", i, exp_b[i]); end
    end
    n_checks++; if (edge_count !== 17'd17) begin n_fail++; $display("FAIL ones_count got %0d exp 17", edge_count); end
  endtask

  task automatic test_mixed();
    logic [7:0] exp_b [3] = '{8'h00, 8'h5A, 8'h01};
    restart_idle();
    mem[9]  = 32'h8000_0000;
    mem[11] = 32'h0001_0000;
    mem[12] = 32'h0000_0100;
    mem[14] = 32'h0000_0002;
    mem[16] = 32'h0000_0040;
    enable = 1'b1;
    collect(300);
    n_checks++; if (timed_out || byte_q.size() != 3) begin n_fail++; $display("FAIL mixed_nbytes got %0d exp 3", byte_q.size()); end
    for (int i = 0; i < 3; i++) begin
      n_checks++;
      if (i >= byte_q.size() || byte_q[i] !== exp_b[i]) begin n_fail++; $display("FAIL mixed_byte%0d exp %h", i, exp_b[i]); end
    end
    n_checks++; if (edge_count !== 17'd5) begin n_fail++; $display("FAIL mixed_count got %0d exp 5", edge_count); end
  endtask

  task automatic test_stall();
    bit         ok;
    int         bad = 0;
    logic [7:0] b0;
    logic [AW-1:0] a0;
    restart_idle();
    mem[0] = 32'h1;
    mem[7] = 32'h10;
    out_ready = 1'b0;
    enable = 1'b1;
    wait_valid(100, ok);
    n_checks++; if (!ok) begin n_fail++; $display("FAIL stall_valid got timeout exp out_valid"); end
    b0 = out_byte;
    a0 = address;
    n_checks++; if (b0 !== 8'h81 || a0 !== AW'(SA + 7)) begin n_fail++; $display("FAIL stall_hold_values got %h/%0d exp 81/%0d", b0, a0, SA + 7); end
    repeat (20) begin
      @(negedge clk);
      if (out_valid !== 1'b1 || out_byte !== b0 || address !== a0) bad++;
    end
    n_checks++; if (bad != 0) begin n_fail++; $display("FAIL stall_stable got %0d unstable cycles exp 0", bad); end
    out_ready = 1'b1;
    collect(300);
    n_checks++;
    if (timed_out || byte_q.size() != 2 || byte_q[0] !== 8'h00 || byte_q[1] !== 8'h00) begin
      n_fail++; $display("FAIL stall_rest got %0d bytes exp 2 zero bytes", byte_q.size());
    end
  endtask

  task automatic test_pause();
    int bad = 0;
    bit found = 1'b0;
    logic [7:0] exp_b [3] = '{8'h81, 8'h00, 8'h00};
    restart_idle();
    mem[0] = 32'h1;
    mem[7] = 32'h2;
    enable = 1'b1;
    for (int c = 0; c < 100; c++) begin
      @(negedge clk);
      if (address == AW'(SA + 3)) begin
        found = 1'b1;
        break;
      end
    end
    n_checks++; if (!found) begin n_fail++; $display("FAIL pause_find got timeout exp address %0d", SA + 3); end
    @(negedge clk);
    pause = 1'b1;
    repeat (5) begin
      @(negedge clk);
      if (address !== AW'(SA + 3) || edge_count !== 17'd1 || out_valid !== 1'b0) bad++;
    end
    pause = 1'b0;
    n_checks++; if (bad != 0) begin n_fail++; $display("FAIL pause_frozen got %0d changed cycles exp 0", bad); end
    collect(300);
    n_checks++; if (timed_out || byte_q.size() != 3) begin n_fail++; $display("FAIL pause_nbytes got %0d exp 3", byte_q.size()); end
    for (int i = 0; i < 3; i++) begin
      n_checks++;
      if (i >= byte_q.size() || byte_q[i] !== exp_b[i]) begin n_fail++; $display("FAIL pause_byte%0d exp %h", i, exp_b[i]); end
    end
    n_checks++; if (edge_count !== 17'd2) begin n_fail++; $display("FAIL pause_count got %0d exp 2", edge_count); end
  endtask

  task automatic test_abort_restart();
    bit ok;
    logic [7:0] exp_b [3] = '{8'hFF, 8'hFF, 8'h01};
    restart_idle();
    for (int i = 0; i < PC; i++) mem[i] = 32'(i + 1);
    out_ready = 1'b0;
    enable = 1'b1;
    wait_valid(100, ok);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    wait_valid(100, ok);
    n_checks++; if (!ok || edge_count !== 17'd16) begin n_fail++; $display("FAIL abort_setup got count %0d exp 16 with byte1 valid", edge_count); end
    enable = 1'b0;
    @(negedge clk);
    n_checks++;
    if (out_valid !== 1'b0 || done !== 1'b0 || out_byte !== 8'h00 || address !== '0) begin
      n_fail++; $display("FAIL abort_outputs got v=%b d=%b b=%h a=%0d exp 0/0/00/0", out_valid, done, out_byte, address);
    end
    n_checks++; if (edge_count !== 17'd16) begin n_fail++; $display("FAIL abort_count_held got %0d exp 16", edge_count); end
    out_ready = 1'b1;
    enable = 1'b1;
    @(negedge clk);
    n_checks++;
    if (address !== AW'(SA) || edge_count !== 17'd0) begin
      n_fail++; $display("FAIL restart_state got a=%0d c=%0d exp %0d/0", address, edge_count, SA);
    end
    collect(300);
    n_checks++; if (timed_out || byte_q.size() != 3) begin n_fail++; $display("FAIL restart_nbytes got %0d exp 3", byte_q.size()); end
    for (int i = 0; i < 3; i++) begin
      n_checks++;
      if (i >= byte_q.size() || byte_q[i] !== exp_b[i]) begin n_fail++; $display("FAIL restart_byte%0d exp %h", i, exp_b[i]); end
    end
  endtask

  task automatic test_done_hold();
    int bad = 0;
    repeat (10) begin
      @(negedge clk);
      if (done !== 1'b1 || address !== '0 || out_valid !== 1'b0) bad++;
    end
    n_checks++; if (bad != 0) begin n_fail++; $display("FAIL done_hold got %0d bad cycles exp 0", bad); end
    enable = 1'b0;
    @(negedge clk);
    n_checks++;
    if (done !== 1'b0 || edge_count !== 17'd17) begin
      n_fail++; $display("FAIL done_clear got d=%b c=%0d exp 0/17", done, edge_count);
    end
  endtask

  task automatic test_async_reset();
    restart_idle();
    for (int i = 0; i < PC; i++) mem[i] = 32'h3;
    out_ready = 1'b0;
    enable = 1'b1;
    repeat (18) @(negedge clk);
    n_checks++; if (out_valid !== 1'b1 || edge_count !== 17'd8) begin n_fail++; $display("FAIL areset_setup got v=%b c=%0d exp 1/8", out_valid, edge_count); end
    #2 reset_n = 1'b0;
    #1;
    n_checks++;
    if (address !== '0 || out_byte !== 8'h00 || out_valid !== 1'b0 || edge_count !== '0 || done !== 1'b0) begin
      n_fail++; $display("FAIL areset_outputs got a=%0d b=%h v=%b c=%0d d=%b exp all 0", address, out_byte, out_valid, edge_count, done);
    end
    @(negedge clk);
    enable = 1'b0;
    reset_n = 1'b1;
    @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_all_zero();
    test_first_byte();
    test_all_ones();
    test_mixed();
    test_stall();
    test_pause();
    test_abort_restart();
    test_done_hold();
    test_async_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got no completion exp finish before 200000");
    $fatal(1, "watchdog expired");
  end

endmodule
